// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall and bubble insertion
module id_ex_stage #(
    parameter int         XLEN            = 32,
    parameter logic [1:0] RESULT_SRC_LOAD = 2'b01
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic            flush_e,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_pc_plus4,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_rd1,
    input  logic [XLEN-1:0] id_rd2,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_reg_write,
    input  logic            id_mem_write,
    input  logic            id_alu_src,
    input  logic            id_branch,
    input  logic            id_jump,
    input  logic [1:0]      id_result_src,
    input  logic [2:0]      id_alu_ctrl,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_pc_plus4,
    output logic [XLEN-1:0] ex_rd1,
    output logic [XLEN-1:0] ex_rd2,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_write,
    output logic            ex_alu_src,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic [1:0]      ex_result_src,
    output logic [2:0]      ex_alu_ctrl,
    output logic            stall_fd
);

    logic w_load_use;
    logic w_bubble;

    // A load in EX whose destination is read by the ID instruction cannot be
    // forwarded in time; rs2 is compared even when unused (a spare stall is harmless).
    always_comb begin
        w_load_use = ex_valid && id_valid
                  && (ex_result_src == RESULT_SRC_LOAD)
                  && (ex_rd != 5'd0)
                  && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
        // A flush redirects fetch, so the stale ID instruction must not be held.
        stall_fd   = w_load_use && !flush_e;
        w_bubble   = flush_e || w_load_use;
    end

    // Pipeline register: capture ID, or insert an all-zero bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || w_bubble) begin
            ex_valid      <= 1'b0;
            ex_pc         <= '0;
            ex_pc_plus4   <= '0;
            ex_rd1        <= '0;
            ex_rd2        <= '0;
            ex_imm        <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_branch     <= 1'b0;
            ex_jump       <= 1'b0;
            ex_result_src <= '0;
            ex_alu_ctrl   <= '0;
        end else begin
            // Control is captured even for an invalid slot; consumers gate with ex_valid.
            ex_valid      <= id_valid;
            ex_pc         <= id_pc;
            ex_pc_plus4   <= id_pc_plus4;
            ex_rd1        <= id_rd1;
            ex_rd2        <= id_rd2;
            ex_imm        <= id_imm;
            ex_rs1        <= id_rs1;
            ex_rs2        <= id_rs2;
            ex_rd         <= id_rd;
            ex_reg_write  <= id_reg_write;
            ex_mem_write  <= id_mem_write;
            ex_alu_src    <= id_alu_src;
            ex_branch     <= id_branch;
            ex_jump       <= id_jump;
            ex_result_src <= id_result_src;
            ex_alu_ctrl   <= id_alu_ctrl;
        end
    end

endmodule
